// File: rtl/ff_jk_bank.sv
// Bank of independent master-slave JK flip-flop channels with sync preset/clear, parallel load
// and an optional slave stage. Define FF_JK_BANK_CONFLICT_EN to build the sticky preset/clear conflict flags.
module ff_jk_bank #(
    parameter int               WIDTH     = 8,
    parameter int               SLAVE     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] S_N,
    input  logic [WIDTH-1:0] R_N,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_N,
    output logic [WIDTH-1:0] CONFLICT
);

    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] m_d;

    // Per-channel master next state: clear beats preset beats load beats JK.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic jk_next;
            assign jk_next = (J[gi] & ~m_q[gi]) | (~K[gi] & m_q[gi]);
            assign m_d[gi] = !R_N[gi]  ? 1'b0 :
                             !S_N[gi]  ? 1'b1 :
                             !EN       ? m_q[gi] :
                             LD        ? D[gi] :
                                         jk_next;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            m_q <= RESET_VAL;
        end else begin
            m_q <= m_d;
        end
    end

    generate
        if (SLAVE != 0) begin : g_slave
            logic [WIDTH-1:0] sv_q;
            // The slave follows the master every edge, independent of EN.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    sv_q <= RESET_VAL;
                end else begin
                    sv_q <= m_q;
                end
            end
            assign Q = sv_q;
        end else begin : g_direct
            assign Q = m_q;
        end
    endgenerate

    assign Q_N = ~Q;

`ifdef FF_JK_BANK_CONFLICT_EN
    logic [WIDTH-1:0] conflict_q;
    logic [WIDTH-1:0] conflict_d;

    assign conflict_d = conflict_q | (~S_N & ~R_N);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign CONFLICT = conflict_q;
`else
    assign CONFLICT = '0;
`endif

endmodule
